// File: rtl/hmsg_arbiter_2to1_pkg.sv
// hmsg_arbiter_2to1 shared definitions: field sizes, debounce depth,
// arbiter state encodings and the round-robin pick helper.
package hmsg_arbiter_2to1_pkg;

  localparam logic NS_ON  = 1'b1;
  localparam logic NS_OFF = 1'b0;

  localparam int NS_ADDRESS_SIZE = 4;
  localparam int NS_DATA_SIZE    = 4;
  localparam int NS_REDUN_SIZE   = 2;
  localparam int NS_REQ_CKS      = 2;

  typedef enum logic [1:0] {
    HARB_ST_IDLE    = 2'd0,
    HARB_ST_SEND    = 2'd1,
    HARB_ST_RELEASE = 2'd2
  } harb_st_e;

  // A tie goes to the input that did not win last time.
  function automatic logic pick_winner(
    input logic r0,
    input logic r1,
    input logic last_win
  );
    return (r0 && r1) ? ~last_win : r1;
  endfunction

endpackage

// File: rtl/hmsg_arbiter_2to1_debouncer.sv
// hreq_debouncer: output follows the raw input only after CKS equal
// consecutive samples; rdy rises once CKS samples have been taken.
module hreq_debouncer
  import hmsg_arbiter_2to1_pkg::*;
#(
  parameter int CKS = NS_REQ_CKS
)(
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic ckd,
  output logic rdy
);

  localparam int CW = (CKS > 1) ? $clog2(CKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CKS - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] warm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ckd  <= NS_OFF;
      rdy  <= NS_OFF;
      cnt  <= '0;
      warm <= '0;
    end else begin
      if (raw != ckd) begin
        if (cnt == LAST) begin
          ckd <= raw;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
      if (!rdy) begin
        if (warm == LAST) rdy <= NS_ON;
        else              warm <= warm + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hmsg_arbiter_2to1.sv
// Round-robin 2:1 merge of 4-phase req/ack message channels.
// Optional per-input completion counters under HMSG_ARB_STATS_EN.
module hmsg_arbiter_2to1
  import hmsg_arbiter_2to1_pkg::*;
#(
  parameter  int ASZ         = NS_ADDRESS_SIZE,
  parameter  int DSZ         = NS_DATA_SIZE,
  parameter  int RSZ         = NS_REDUN_SIZE,
  parameter  int RCV_REQ_CKS = NS_REQ_CKS,
  localparam int MSZ         = ASZ + DSZ + RSZ
)(
  input  logic           gch_clk,
  input  logic           gch_reset,
  output logic           gch_ready,
  input  logic           rcv0_req_in,
  output logic           rcv0_ack_out,
  input  logic [MSZ-1:0] rcv0_msg_in,
  input  logic           rcv1_req_in,
  output logic           rcv1_ack_out,
  input  logic [MSZ-1:0] rcv1_msg_in,
  output logic           snd0_req_out,
  input  logic           snd0_ack_in,
  output logic [MSZ-1:0] snd0_msg_out
`ifdef HMSG_ARB_STATS_EN
  ,
  output logic [15:0]    stat_cnt0,
  output logic [15:0]    stat_cnt1
`endif
);

  logic rcv0_ckd_req, rcv1_ckd_req, snd0_ckd_ack;
  logic rdy0, rdy1, rdy_s;

  hreq_debouncer #(.CKS(RCV_REQ_CKS)) u_db_rcv0 (
    .clk(gch_clk), .rst(gch_reset), .raw(rcv0_req_in),
    .ckd(rcv0_ckd_req), .rdy(rdy0)
  );
  hreq_debouncer #(.CKS(RCV_REQ_CKS)) u_db_rcv1 (
    .clk(gch_clk), .rst(gch_reset), .raw(rcv1_req_in),
    .ckd(rcv1_ckd_req), .rdy(rdy1)
  );
  hreq_debouncer #(.CKS(RCV_REQ_CKS)) u_db_snd0 (
    .clk(gch_clk), .rst(gch_reset), .raw(snd0_ack_in),
    .ckd(snd0_ckd_ack), .rdy(rdy_s)
  );

  harb_st_e       state, state_nx;
  logic           rg_rdy;
  logic           cur, cur_nx;
  logic           last_win, last_win_nx;
  logic           snd_req_nx, ack0_nx, ack1_nx;
  logic [MSZ-1:0] msg_nx;
  logic           done;
  logic           elig0, elig1, win, cur_req;

  assign gch_ready = rg_rdy & rdy0 & rdy1;

  assign elig0   = rcv0_ckd_req & ~rcv0_ack_out;
  assign elig1   = rcv1_ckd_req & ~rcv1_ack_out;
  assign win     = pick_winner(elig0, elig1, last_win);
  assign cur_req = cur ? rcv1_ckd_req : rcv0_ckd_req;

  always_comb begin
    state_nx    = state;
    cur_nx      = cur;
    last_win_nx = last_win;
    snd_req_nx  = snd0_req_out;
    ack0_nx     = rcv0_ack_out;
    ack1_nx     = rcv1_ack_out;
    msg_nx      = snd0_msg_out;
    done        = 1'b0;
    unique case (state)
      HARB_ST_IDLE: begin
        if (rg_rdy && rdy_s && (elig0 || elig1)) begin
          msg_nx     = win ? rcv1_msg_in : rcv0_msg_in;
          cur_nx     = win;
          snd_req_nx = 1'b1;
          state_nx   = HARB_ST_SEND;
        end
      end
      HARB_ST_SEND: begin
        if (snd0_ckd_ack) begin
          snd_req_nx = 1'b0;
          if (cur) ack1_nx = 1'b1;
          else     ack0_nx = 1'b1;
          state_nx = HARB_ST_RELEASE;
        end
      end
      HARB_ST_RELEASE: begin
        if (!snd0_ckd_ack && !cur_req) begin
          ack0_nx     = 1'b0;
          ack1_nx     = 1'b0;
          last_win_nx = cur;
          done        = 1'b1;
          state_nx    = HARB_ST_IDLE;
        end
      end
      default: state_nx = HARB_ST_IDLE;
    endcase
  end

  always_ff @(posedge gch_clk or posedge gch_reset) begin
    if (gch_reset) begin
      state        <= HARB_ST_IDLE;
      rg_rdy       <= NS_OFF;
      cur          <= 1'b0;
      last_win     <= 1'b1;
      snd0_req_out <= NS_OFF;
      rcv0_ack_out <= NS_OFF;
      rcv1_ack_out <= NS_OFF;
      snd0_msg_out <= '0;
    end else begin
      state        <= state_nx;
      rg_rdy       <= NS_ON;
      cur          <= cur_nx;
      last_win     <= last_win_nx;
      snd0_req_out <= snd_req_nx;
      rcv0_ack_out <= ack0_nx;
      rcv1_ack_out <= ack1_nx;
      snd0_msg_out <= msg_nx;
    end
  end

`ifdef HMSG_ARB_STATS_EN
  always_ff @(posedge gch_clk or posedge gch_reset) begin
    if (gch_reset) begin
      stat_cnt0 <= '0;
      stat_cnt1 <= '0;
    end else if (done) begin
      if (cur) stat_cnt1 <= stat_cnt1 + 16'd1;
      else     stat_cnt0 <= stat_cnt0 + 16'd1;
    end
  end
`endif

endmodule

// File: doc/hmsg_arbiter_2to1.md
Name: hmsg_arbiter_2to1

Overview:
- Round-robin merge of two inbound 4-phase req/ack message channels (rcv0, rcv1) onto one outbound channel (snd0).
- Sits in the hgen_net fabric wherever two routing paths converge on one link, e.g. ahead of a sink or a cell input port.
- Each message is latched and forwarded whole. The input is acknowledged only after the downstream has acknowledged, so back-pressure propagates end to end.

Parameters:
- ASZ, `NS_ADDRESS_SIZE, message address field width.
- DSZ, `NS_DATA_SIZE, message data field width.
- RSZ, `NS_REDUN_SIZE, redundancy field width.
- RCV_REQ_CKS, `NS_REQ_CKS, consecutive stable cycles for an input req to count as asserted or deasserted.
- Derived constant: MSZ = ASZ+DSZ+RSZ.

Ports:
- gch_clk  in  1  clock.
- gch_reset  in  1  reset, asynchronous, active-high.
- gch_ready  out  1  block ready: internal ready flag AND both input debouncers ready.
- rcv0_req_in  in  1  input 0 request.
- rcv0_ack_out  out  1  input 0 acknowledge.
- rcv0_msg_in  in  MSZ  input 0 message {addr,data,redun}.
- rcv1_req_in  in  1  input 1 request.
- rcv1_ack_out  out  1  input 1 acknowledge.
- rcv1_msg_in  in  MSZ  input 1 message.
- snd0_req_out  out  1  output request.
- snd0_ack_in  in  1  output acknowledge.
- snd0_msg_out  out  MSZ  output message (registered).

Behaviour:
- Reset (async, immediate): state=IDLE; rg_rdy=0; both ack_out=0; snd0_req_out=0; snd0_msg_out=0; last_win=1, so input 0 wins the first tie.
- Ready flag: rg_rdy is set on the first clock edge after reset deasserts. No arbitration while rg_rdy=0.
- Debounce: rcvN_ckd_req follows rcvN_req_in only after RCV_REQ_CKS equal consecutive samples. snd0_ack_in uses the same debounce (snd0_ckd_ack).
- IDLE:
  - If exactly one ckd_req=1 and its ack_out=0: that input is the winner.
  - If both: the winner is the input != last_win.
  - On the grant edge: latch the winner's msg into snd0_msg_out, set cur=winner, snd0_req_out<=1, go to SEND.
- SEND:
  - On snd0_ckd_ack=1: snd0_req_out<=0, rcv[cur]_ack_out<=1, go to RELEASE.
- RELEASE:
  - Wait until snd0_ckd_ack=0 AND rcv[cur]_ckd_req=0.
  - Then rcv[cur]_ack_out<=0, last_win<=cur, go to IDLE.
  - The two conditions may arrive in either order or the same cycle.
- Minimum cycles from the grant to the next possible grant: 2 + 2*RCV_REQ_CKS plus handshake latency. No pipelining; at most one message in flight.
- The loser's request is held pending (ack stays 0). It is served on the next IDLE evaluation. No starvation: with both inputs continuously requesting, grants strictly alternate.
- Input msg is sampled only on the grant edge. Changes afterwards are ignored.
- An input req that drops during SEND (protocol violation) is ignored until RELEASE. The message is still delivered.
- Reset mid-transfer: all outputs are forced low immediately. The transfer is discarded, not resumed.

Optional Feature:
- Macro: HMSG_ARB_STATS_EN.
- With the macro defined, add outputs:
  - stat_cnt0 out 16: counts messages completed from input 0 (RELEASE→IDLE).
  - stat_cnt1 out 16: same for input 1.
  - Counters wrap 16'hFFFF→0 and reset to 0.
- Without the macro: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package/header (hglobal.v): `NS_ON/`NS_OFF, size defaults, `NS_REQ_CKS, state encodings HARB_ST_IDLE=0, HARB_ST_SEND=1, HARB_ST_RELEASE=2.
- One sub-module, hreq_debouncer (param CKS):
  - Inputs: clk, async reset, raw signal.
  - Outputs: ckd (debounced signal) and rdy (ready).
  - Instantiated three times (rcv0 req, rcv1 req, snd0 ack).

Test Plan:
1. Reset, then a single request on rcv0 with msg=0x0A5 (ASZ=DSZ=4, RSZ=2 scaled accordingly): snd0_msg_out=0x0A5, snd0_req_out=1. After the sink acks, rcv0_ack_out=1. rcv0 and snd0 release, then both return to 0; state is IDLE.
2. Both rcv0 and rcv1 request in the same cycle from reset, msgs 0x111 and 0x222: delivery order is 0x111 then 0x222, with rcv1_ack_out=0 throughout the first transfer.
3. Both inputs request continuously for 6 messages: grant sequence is 0,1,0,1,0,1. With HMSG_ARB_STATS_EN, stat_cnt0=3 and stat_cnt1=3.
4. Sink holds snd0_ack_in=0 for 50 cycles: snd0_req_out stays 1 and both ack_outs stay 0. Once ack arrives, delivery completes normally.
5. gch_reset asserted in SEND state: snd0_req_out and all acks go to 0 in the same cycle without a clock edge. gch_ready=0 until one edge after release and debouncers are ready.
6. rcv0_msg_in changed from 0x0A5 to 0x3C3 one cycle after the grant: snd0_msg_out remains 0x0A5. A glitch on rcv1_req shorter than RCV_REQ_CKS cycles causes no grant.
